// File: rtl/mult_sequencer_if.sv
//------------------------------------------------------------------------------
// mult_sequencer_if : two-requester operand bus and result channel of the
//                     shift-add multiplier sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mult_sequencer_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH + 2);

   logic                 req0_valid;
   logic                 req1_valid;
   logic [WIDTH-1:0]     req0_a;
   logic [WIDTH-1:0]     req0_b;
   logic [WIDTH-1:0]     req1_a;
   logic [WIDTH-1:0]     req1_b;
   logic                 req0_ready;
   logic                 req1_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;
   logic                 out_id;
   logic [CW-1:0]        out_cycles;
   logic                 busy;

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, out_ready,
      input  req0_ready, req1_ready, out_valid, out_product, out_id, out_cycles, busy
   );

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, out_ready,
      output req0_ready, req1_ready, out_valid, out_product, out_id, out_cycles, busy
   );
endinterface

`default_nettype wire

// File: rtl/mult_sequencer.sv
//------------------------------------------------------------------------------
// mult_sequencer : arbitrated sequential multiplier that adds one shifted
//                  multiplicand per set multiplier bit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mult_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   mult_sequencer_if.slave  bus
);
   localparam int PW = 2 * WIDTH;
   localparam int SW = $clog2(PW);
   localparam int CW = $clog2(WIDTH + 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [WIDTH-1:0] r_areg;
   logic [WIDTH-1:0] r_breg;
   logic             r_id;
   logic             r_last_grant;
   logic [PW-1:0]    r_acc;
   logic [SW-1:0]    r_shifted;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_product;
   logic             r_out_id;
   logic [CW-1:0]    r_out_cycles;

   logic             w_grant_vld;
   logic             w_grant_id;
   logic [SW-1:0]    w_k;
   logic [PW-1:0]    w_addend;

   // Scan downward so the last hit is the lowest set bit.
   always_comb begin
      w_k = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (r_breg[i]) w_k = SW'(i);
      end
   end

   assign w_addend = {{WIDTH{1'b0}}, r_areg} << (r_shifted + w_k);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_grant_vld = 1'b0;
      w_grant_id  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_grant_vld = bus.req0_valid | bus.req1_valid;
            w_grant_id  = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
            if (w_grant_vld) w_next = S_RUN;
         end
         S_RUN:   if (r_breg == '0) w_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_areg       <= '0;
         r_breg       <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_acc        <= '0;
         r_shifted    <= '0;
         r_cnt        <= '0;
         r_product    <= '0;
         r_out_id     <= 1'b0;
         r_out_cycles <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_areg       <= w_grant_id ? bus.req1_a : bus.req0_a;
                  r_breg       <= w_grant_id ? bus.req1_b : bus.req0_b;
                  r_id         <= w_grant_id;
                  r_last_grant <= w_grant_id;
                  r_acc        <= '0;
                  r_shifted    <= '0;
                  r_cnt        <= '0;
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_breg != '0) begin
                  r_acc     <= r_acc + w_addend;
                  r_breg    <= r_breg >> (w_k + SW'(1));
                  r_shifted <= r_shifted + w_k + SW'(1);
               end else begin
                  // Final RUN cycle: publish including this cycle's count.
                  r_product    <= r_acc;
                  r_out_id     <= r_id;
                  r_out_cycles <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready  = w_grant_vld & ~w_grant_id;
   assign bus.req1_ready  = w_grant_vld &  w_grant_id;
   assign bus.out_valid   = (r_state == S_DONE);
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.out_product = r_product;
   assign bus.out_id      = r_out_id;
   assign bus.out_cycles  = r_out_cycles;

endmodule

`default_nettype wire

// File: tb/tb_mult_sequencer.sv
//------------------------------------------------------------------------------
// tb_mult_sequencer : directed vectors for the arbitrated shift-add multiplier.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_sequencer;
   localparam int WIDTH = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

   mult_sequencer #(.WIDTH(WIDTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until out_valid rises; the number of edges taken is checked.
   task automatic wait_done(input string tag, input int exp_edges);
      int n;
      n = 0;
      while (n < 20) begin
         tick();
         n++;
         if (bus.out_valid === 1'b1) break;
      end
      chk(tag, n, exp_edges);
   endtask

   task automatic chk_result(input string tag, input int prod, input int id, input int cyc);
      chk({tag, "_prod"}, 32'(bus.out_product), prod);
      chk({tag, "_id"},   32'(bus.out_id),      id);
      chk({tag, "_cyc"},  32'(bus.out_cycles),  cyc);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 4'd13; bus.req0_b = 4'd11;
      bus.req1_valid = 1'b0; bus.req1_a = 4'd0;  bus.req1_b = 4'd0;
      bus.out_ready  = 1'b0;

      // Reset held two cycles with a pending request
      tick(); tick();
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_busy",  32'(bus.busy), 0);
      chk_result("rst", 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("rel_rdy0", 32'(bus.req0_ready), 1);
      chk("rel_rdy1", 32'(bus.req1_ready), 0);

      // 13 x 11: popcount 3 -> four RUN cycles
      tick();
      bus.req0_valid = 1'b0;
      chk("run_busy", 32'(bus.busy), 1);
      chk("run_rdy0", 32'(bus.req0_ready), 0);
      wait_done("lat_13x11", 4);
      chk_result("r13x11", 143, 0, 4);

      // Stall in DONE with a request waiting
      bus.req1_valid = 1'b1; bus.req1_a = 4'd9; bus.req1_b = 4'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk_result("stall", 143, 0, 4);
         chk("stall_rdy0", 32'(bus.req0_ready), 0);
         chk("stall_rdy1", 32'(bus.req1_ready), 0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("rel_valid", 32'(bus.out_valid), 0);
      chk("rel_busy",  32'(bus.busy), 0);
      chk("hold_prod", 32'(bus.out_product), 143);

      // 9 x 0 from requester 1
      chk("z_rdy1", 32'(bus.req1_ready), 1);
      tick();
      bus.req1_valid = 1'b0;
      wait_done("lat_9x0", 1);
      chk_result("r9x0", 0, 1, 1);
      tick();

      // Arbitration after reset: both valid, requester 0 first
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 4'd15; bus.req0_b = 4'd15;
      bus.req1_valid = 1'b1; bus.req1_a = 4'd3;  bus.req1_b = 4'd5;
      #1;
      chk("arb_rdy0", 32'(bus.req0_ready), 1);
      chk("arb_rdy1", 32'(bus.req1_ready), 0);
      tick();
      bus.req0_a = 4'd6; bus.req0_b = 4'd7;
      wait_done("lat_15x15", 5);
      chk_result("r15x15", 225, 0, 5);
      tick();
      chk("arb2_rdy0", 32'(bus.req0_ready), 0);
      chk("arb2_rdy1", 32'(bus.req1_ready), 1);
      tick();
      bus.req1_a = 4'd2; bus.req1_b = 4'd2;
      wait_done("lat_3x5", 3);
      chk_result("r3x5", 15, 1, 3);
      tick();
      chk("arb3_rdy0", 32'(bus.req0_ready), 1);
      chk("arb3_rdy1", 32'(bus.req1_ready), 0);
      tick();
      bus.req0_valid = 1'b0;
      wait_done("lat_6x7", 4);
      chk_result("r6x7", 42, 0, 4);
      tick();
      tick();
      bus.req1_valid = 1'b0;
      wait_done("lat_2x2", 2);
      chk_result("r2x2", 4, 1, 2);
      tick();

      // Reset during RUN discards the operation
      bus.req0_valid = 1'b1; bus.req0_a = 4'd15; bus.req0_b = 4'd15;
      tick();
      tick(); tick();
      chk("mid_busy", 32'(bus.busy), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort_busy",  32'(bus.busy), 0);
      chk("abort_valid", 32'(bus.out_valid), 0);
      chk("abort_prod",  32'(bus.out_product), 0);
      chk("abort_rdy0",  32'(bus.req0_ready), 1);
      tick();
      bus.req0_valid = 1'b0;
      wait_done("lat_reissue", 5);
      chk_result("reissue", 225, 0, 5);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire
